// File: rtl/fifo_order_arbiter_pkg.sv
// arb_pkg: shared types, width helpers and defaults for fifo_order_arbiter.
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANTED} arb_state_t;
  localparam int N_REQ_DEF = 4;
  localparam int MAX_HOLD_DEF = 8;
  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/fifo_order_arbiter_if.sv
// fifo_order_arbiter_if: request/grant bundle between masters and the arbiter.
interface fifo_order_arbiter_if import arb_pkg::*; #(parameter int N_REQ = N_REQ_DEF);
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] grant_o;
  logic [ID_W(N_REQ)-1:0] grant_id_o;
  logic grant_valid_o;
  logic [CNT_W(N_REQ)-1:0] queue_count_o;
  modport master (output req_i, input grant_o, grant_id_o, grant_valid_o, queue_count_o);
  modport slave (input req_i, output grant_o, grant_id_o, grant_valid_o, queue_count_o);
endinterface

// File: rtl/fifo_order_arbiter_fifo.sv
// arb_id_fifo: circular id buffer; multi-push in ascending index order plus one trailing push, single pop.
module arb_id_fifo import arb_pkg::*; #(
  parameter int N = N_REQ_DEF,
  localparam int IW = ID_W(N),
  localparam int CW = CNT_W(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  push_vec,
  input  logic          extra_push,
  input  logic [IW-1:0] extra_id,
  input  logic          pop,
  output logic [IW-1:0] head,
  output logic [CW-1:0] count
);
  logic [IW-1:0] mem [N];
  logic [IW-1:0] wr_id [N];
  logic [N-1:0]  wr_en;
  logic [IW-1:0] rd, rd_n;
  logic [CW-1:0] count_n;
  // The pop only advances rd, so pushes always start at the pre-edge tail.
  always_comb begin
    int p;
    logic [IW-1:0] w;
    wr_en = '0;
    for (int j = 0; j < N; j++) wr_id[j] = '0;
    p = int'(rd) + int'(count);
    for (int k = 0; k < N; k++) begin
      w = IW'(p % N);
      if (push_vec[k]) begin
        wr_en[w] = 1'b1;
        wr_id[w] = IW'(k);
        p++;
      end
    end
    w = IW'(p % N);
    if (extra_push) begin
      wr_en[w] = 1'b1;
      wr_id[w] = extra_id;
      p++;
    end
    count_n = CW'(p - int'(rd) - int'(pop));
    rd_n = pop ? ((rd == IW'(N - 1)) ? '0 : rd + 1'b1) : rd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      count <= '0;
      for (int j = 0; j < N; j++) mem[j] <= '0;
    end else begin
      rd <= rd_n;
      count <= count_n;
      for (int j = 0; j < N; j++) if (wr_en[j]) mem[j] <= wr_id[j];
    end
  end
  assign head = mem[rd];
endmodule

// File: rtl/fifo_order_arbiter.sv
// fifo_order_arbiter: first-come-first-served arbiter, grants in order of request rising edges.
// Optional hold-timeout preemption enabled by defining ARB_TIMEOUT_EN.
module fifo_order_arbiter import arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic clk,
  input logic rst_n,
  fifo_order_arbiter_if.slave bus
);
  localparam int IW = ID_W(N_REQ);
  arb_state_t state, state_n;
  logic [N_REQ-1:0] req_q, rise, queued, push_vec, pop_mask, requeue_mask;
  logic [IW-1:0] owner, owner_n, head;
  logic [CNT_W(N_REQ)-1:0] count;
  logic empty, rel, preempt, pop, handover, requeue, expired;
  assign rise = bus.req_i & ~req_q;
  assign push_vec = rise & ~queued;
  assign empty = count == '0;
  // A popped head that no longer requests is simply discarded.
  always_comb begin
    rel = state == ARB_GRANTED && !bus.req_i[owner];
    preempt = state == ARB_GRANTED && bus.req_i[owner] && expired;
    pop = (state == ARB_IDLE || rel || preempt) && !empty;
    handover = pop && bus.req_i[head];
    requeue = handover && preempt;
    state_n = handover ? ARB_GRANTED : rel ? ARB_IDLE : state;
    owner_n = handover ? head : owner;
    pop_mask = pop ? N_REQ'(1) << head : '0;
    requeue_mask = requeue ? N_REQ'(1) << owner : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      queued <= '0;
      state <= ARB_IDLE;
      owner <= '0;
    end else begin
      req_q <= bus.req_i;
      queued <= (queued & ~pop_mask) | push_vec | requeue_mask;
      state <= state_n;
      owner <= owner_n;
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  // Preempt on the edge where the counter would reach MAX_HOLD: the owner gets MAX_HOLD cycles.
  assign expired = 9'(hold_cnt) + 9'd1 >= 9'(MAX_HOLD);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else if (handover) hold_cnt <= '0;
    else if (state == ARB_GRANTED && hold_cnt != 8'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = MAX_HOLD > 0;
  assign expired = 1'b0;
`endif
  arb_id_fifo #(.N(N_REQ)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_vec(push_vec),
    .extra_push(requeue),
    .extra_id(owner),
    .pop(pop),
    .head(head),
    .count(count)
  );
  assign bus.grant_valid_o = state == ARB_GRANTED;
  assign bus.grant_o = bus.grant_valid_o ? N_REQ'(1) << owner : '0;
  assign bus.grant_id_o = bus.grant_valid_o ? owner : '0;
  assign bus.queue_count_o = count;
endmodule

// File: tb/tb_fifo_order_arbiter.sv
// tb_fifo_order_arbiter: table-driven directed check of fifo_order_arbiter (N_REQ=4); timeout part under ARB_TIMEOUT_EN.
module tb_fifo_order_arbiter;
`ifdef ARB_TIMEOUT_EN
  localparam int MH = 3;
`else
  localparam int MH = 8;
`endif
  typedef struct {
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic [2:0] c;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  fifo_order_arbiter_if #(.N_REQ(4)) bus ();
  fifo_order_arbiter #(.N_REQ(4), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [3:0] g, input logic [1:0] id, input logic v, input logic [2:0] c);
    n_vec++;
    if (bus.grant_o !== g || bus.grant_id_o !== id || bus.grant_valid_o !== v || bus.queue_count_o !== c) begin
      n_err++;
      $display("FAIL %s: got grant=%b id=%0d valid=%b count=%0d, want grant=%b id=%0d valid=%b count=%0d",
               name, bus.grant_o, bus.grant_id_o, bus.grant_valid_o, bus.queue_count_o, g, id, v, c);
    end
  endtask
  task automatic step(input string name, input logic [3:0] r, input logic [3:0] g, input logic [1:0] id,
                      input logic v, input logic [2:0] c);
    bus.req_i = r;
    @(posedge clk);
    #1;
    check(name, g, id, v, c);
  endtask
  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id, input logic v, input logic [2:0] c);
    tbl.push_back('{r, g, id, v, c});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req_i = '0;
    #12;
    check("reset_state", 4'b0000, 2'd0, 1'b0, 3'd0);
    rst_n = 1'b1;
    // single request: enqueue, then grant one edge later
    add(4'b0100, 4'b0000, 0, 0, 1);
    add(4'b0100, 4'b0100, 2, 1, 0);
    add(4'b0100, 4'b0100, 2, 1, 0);
    add(4'b0000, 4'b0000, 0, 0, 0);
    // simultaneous rises: 1 then 3, same-edge handover
    add(4'b1010, 4'b0000, 0, 0, 2);
    add(4'b1010, 4'b0010, 1, 1, 1);
    add(4'b1010, 4'b0010, 1, 1, 1);
    add(4'b1000, 4'b1000, 3, 1, 0);
    add(4'b1000, 4'b1000, 3, 1, 0);
    add(4'b0000, 4'b0000, 0, 0, 0);
    // arrival order 2 then 1 behind owner 0
    add(4'b0001, 4'b0000, 0, 0, 1);
    add(4'b0001, 4'b0001, 0, 1, 0);
    add(4'b0101, 4'b0001, 0, 1, 1);
    add(4'b0111, 4'b0001, 0, 1, 2);
    add(4'b0110, 4'b0100, 2, 1, 1);
    add(4'b0010, 4'b0010, 1, 1, 0);
    add(4'b0000, 4'b0000, 0, 0, 0);
    // queued requester 3 drops before its turn
    add(4'b0001, 4'b0000, 0, 0, 1);
    add(4'b0001, 4'b0001, 0, 1, 0);
    add(4'b1001, 4'b0001, 0, 1, 1);
    add(4'b0001, 4'b0001, 0, 1, 1);
    add(4'b0000, 4'b0000, 0, 0, 0);
    add(4'b0000, 4'b0000, 0, 0, 0);
    // idle pop discards a withdrawn request
    add(4'b0010, 4'b0000, 0, 0, 1);
    add(4'b0000, 4'b0000, 0, 0, 0);
    add(4'b0000, 4'b0000, 0, 0, 0);
    // re-rise of a queued requester is ignored
    add(4'b0011, 4'b0000, 0, 0, 2);
    add(4'b0011, 4'b0001, 0, 1, 1);
    add(4'b0001, 4'b0001, 0, 1, 1);
    add(4'b0011, 4'b0001, 0, 1, 1);
    add(4'b0010, 4'b0010, 1, 1, 0);
    add(4'b0000, 4'b0000, 0, 0, 0);
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].req, tbl[i].g, tbl[i].id, tbl[i].v, tbl[i].c);
    // asynchronous reset mid-grant with two entries queued
    step("rst_pre_a", 4'b1110, 4'b0000, 0, 0, 3);
    step("rst_pre_b", 4'b1110, 4'b0010, 1, 1, 2);
    #3 rst_n = 1'b0;
    #1 check("rst_async", 4'b0000, 0, 0, 0);
    bus.req_i = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step("rst_post_a", 4'b0000, 4'b0000, 0, 0, 0);
    step("rst_post_b", 4'b0000, 4'b0000, 0, 0, 0);
    step("rst_fresh_a", 4'b1000, 4'b0000, 0, 0, 1);
    step("rst_fresh_b", 4'b1000, 4'b1000, 3, 1, 0);
    step("rst_fresh_c", 4'b0000, 4'b0000, 0, 0, 0);
`ifdef ARB_TIMEOUT_EN
    // owner 0 preempted after 3 held cycles, re-queued behind nothing
    step("to_a", 4'b0001, 4'b0000, 0, 0, 1);
    step("to_b", 4'b0001, 4'b0001, 0, 1, 0);
    step("to_c", 4'b0011, 4'b0001, 0, 1, 1);
    step("to_d", 4'b0011, 4'b0001, 0, 1, 1);
    step("to_preempt", 4'b0011, 4'b0010, 1, 1, 1);
    step("to_back", 4'b0001, 4'b0001, 0, 1, 0);
    for (int i = 0; i < 6; i++) step($sformatf("to_keep%0d", i), 4'b0001, 4'b0001, 0, 1, 0);
    step("to_end", 4'b0000, 4'b0000, 0, 0, 0);
`else
    // without timeout the owner holds indefinitely
    step("hold_a", 4'b0001, 4'b0000, 0, 0, 1);
    step("hold_b", 4'b0001, 4'b0001, 0, 1, 0);
    for (int i = 0; i < 12; i++) step($sformatf("hold%0d", i), 4'b0011, 4'b0001, 0, 1, 1);
    step("hold_rel", 4'b0010, 4'b0010, 1, 1, 0);
    step("hold_end", 4'b0000, 4'b0000, 0, 0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_order_arbiter.md
# fifo_order_arbiter

Parametrised first-come-first-served arbiter for N requesters, the successor to the fixed 4-requester queue arbiter. Requests are served strictly in order of their rising edges; each grant is held until the owner drops its request. The block sits between requesting masters and a single shared resource, and drives a registered one-hot grant plus its encoded index. An optional hold timeout preempts long owners.

## Interface
- N_REQ, 4, number of requesters (2..16)
- MAX_HOLD, 8, grant-hold limit in cycles; used only with ARB_TIMEOUT_EN (1..255)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  N_REQ  level requests; bit k belongs to requester k
- grant_o  out  N_REQ  registered one-hot grant; all zero when idle
- grant_id_o  out  $clog2(N_REQ)  index of the granted requester; 0 when idle
- grant_valid_o  out  1  high while any grant is active
- queue_count_o  out  $clog2(N_REQ+1)  number of queued, not-yet-granted requesters

## Operation
- Rise detection: rise = req_i & ~req_q, where req_q is req_i registered; req_q resets to 0.
- Per-requester queued flag: a rise on a requester whose flag is clear pushes its id to the tail and sets the flag. A rise on a requester whose flag is set is ignored; the entry keeps its position.
- Simultaneous rises are pushed in ascending index order; the lowest index is nearest the head.
- The queue is a circular buffer of depth N_REQ holding ids. It cannot overflow because each requester has at most one entry.
- FSM states are IDLE and GRANTED.
- IDLE, queue non-empty: pop the head and clear its flag. If req_i[head] is 1, grant the head and go to GRANTED. Otherwise discard the entry, issue no grant, and retry on the next edge.
- GRANTED, req_i[owner] = 0: release. In the same edge, pop the head using the same rule as IDLE. If the head is granted, stay in GRANTED (back-to-back). Otherwise go to IDLE.
- GRANTED, req_i[owner] = 1: hold the grant.
- Pushes and the pop in one edge: the pop takes the pre-edge head, then the pushes append.

## Timing
- Reset values: grant_o = 0, grant_id_o = 0, grant_valid_o = 0, queue_count_o = 0, FSM = IDLE, queue empty, all flags clear, req_q = 0.
- Latency: with the queue empty, a rise sampled at edge t is enqueued at t. The grant is visible after edge t+1.
- Release latency: a request dropped before edge t clears grant_o at edge t. The next head is granted at that same edge t.
- A request that drops before its grant is never granted. Its entry is consumed by one idle pop cycle.
- grant_o, grant_id_o and grant_valid_o change only on clock edges. Only reset changes them asynchronously.
- queue_count_o reflects the post-edge queue occupancy.
- Asserting rst_n low mid-grant clears the grant immediately and empties the queue.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter resets to 0 on each new grant and increments each edge while GRANTED.
  - When the counter reaches MAX_HOLD, the owner's request is still high and the queue is non-empty, the owner is preempted. At that edge the head is popped and granted, and the owner's id is pushed to the tail after that edge's new rises, with its flag set.
  - If the queue is empty at that point, the grant is kept and the counter saturates.
- ARB_TIMEOUT_EN undefined: no counter exists, MAX_HOLD is ignored, and a grant is held indefinitely.

## Structure
- Package arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_GRANTED)
  - the ID_W and CNT_W width helper functions
  - the default N_REQ and MAX_HOLD constants
- One sub-module, arb_id_fifo: a circular id buffer with a multi-push vector port (ascending order) and a single pop port, exposing head and count.

## Test plan
- N_REQ=4, reset, then req_i=4'b0100 -> grant_o=4'b0100 and grant_id_o=2 two edges after the rise; queue_count_o=0.
- req_i rises 4'b1010 in one cycle -> grant order is 1 then 3; each owner holds until its bit drops, and the handover occurs in the same edge as the release.
- Requester 0 granted, requesters 2 then 1 rise on consecutive cycles, requester 0 drops -> grant to 2, then to 1; queue_count_o goes 2, 1, 0.
- Requester 3 queued behind owner 0, requester 3 drops before its turn, then requester 0 releases -> one idle cycle with grant_o=0, then IDLE; requester 3 is never granted.
- Reset asserted while grant_o=4'b0010 with 2 entries queued -> all outputs 0 asynchronously; after release, no grant until a fresh rise.
- With ARB_TIMEOUT_EN and MAX_HOLD=3: requester 0 holds, requester 1 is waiting -> requester 1 granted after 3 held edges and requester 0 re-queued, queue_count_o=1. With no waiter, requester 0 keeps the grant.
